// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: upstream controller for the loadable down counter in
// the serial transmitter path. It parses a frame on ser_in (start bit, port
// number, payload length, guard bit), then loads the counter with the length.
// It enables the counter once per payload bit and steers each payload bit to
// the addressed output port. The counter's co flag marks the last payload bit.
//
// Frame, MSB first: 0 | port[PORT_W] | len[LEN_W] | guard | len data bits
//
// Optional feature macro: PARITY_EN
//   defined   -> one even-parity bit follows the payload; parity_err is
//                presented alongside done.
//   undefined -> no parity state or accumulator; parity_err is tied low.
module serial_frame_ctrl #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ser_in,
  input  logic                   cnt_co,
  output logic                   cnt_ld,
  output logic                   cnt_cen,
  output logic [LEN_W-1:0]       cnt_par_ld,
  output logic [2**PORT_W-1:0]   port_en,
  output logic                   ser_out,
  output logic                   busy,
  output logic                   done,
  output logic                   parity_err
);

  localparam int NPORT = 2**PORT_W;
  localparam int MAXF  = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int CNT_W = $clog2(MAXF + 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    IDLE, HDR, LEN, LOAD, DATA, PAR, DONE
  } state_t;
  // State that follows the payload (or an empty payload).
  localparam state_t TAIL = PAR;
`else
  typedef enum logic [2:0] {
    IDLE, HDR, LEN, LOAD, DATA, DONE
  } state_t;
  localparam state_t TAIL = DONE;
`endif

  state_t               state;
  state_t               state_n;
  logic [PORT_W-1:0]    port_reg;
  logic [LEN_W-1:0]     len_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 data_q;
  logic [NPORT-1:0]     port_dec;

  assign cnt_par_ld = len_reg;
  // Payload passes straight through only while in DATA.
  assign ser_out    = data_q & ser_in;

  // Decode the captured port number to a one-hot strobe pattern.
  always_comb begin
    port_dec = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      port_dec[i] = (port_reg == PORT_W'(i));
    end
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (!ser_in) state_n = HDR;
      HDR:  if (bit_cnt == CNT_W'(PORT_W - 1)) state_n = LEN;
      LEN:  if (bit_cnt == CNT_W'(LEN_W - 1)) state_n = LOAD;
      LOAD: state_n = (len_reg == '0) ? TAIL : DATA;
      DATA: if (cnt_co) state_n = TAIL;
`ifdef PARITY_EN
      PAR:  state_n = DONE;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM register, header shift registers and registered Moore outputs.
  // Outputs are decoded from state_n so that they are valid in the same
  // cycle the FSM occupies the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      port_reg <= '0;
      len_reg  <= '0;
      bit_cnt  <= '0;
      cnt_ld   <= 1'b0;
      cnt_cen  <= 1'b0;
      port_en  <= '0;
      data_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: bit_cnt <= '0;
        HDR: begin
          port_reg <= PORT_W'({port_reg, ser_in});
          bit_cnt  <= (state_n == LEN) ? '0 : bit_cnt + CNT_W'(1);
        end
        LEN: begin
          len_reg <= LEN_W'({len_reg, ser_in});
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
      busy    <= (state_n != IDLE);
      cnt_ld  <= (state_n == LOAD);
      cnt_cen <= (state_n == DATA);
      data_q  <= (state_n == DATA);
      done    <= (state_n == DONE);
      port_en <= (state_n == DATA) ? port_dec : '0;
    end
  end

`ifdef PARITY_EN
  logic par_acc;
  logic perr_q;

  assign parity_err = perr_q;

  // Accumulate payload parity and register the comparison for the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        par_acc <= 1'b0;
      end else if (state == DATA) begin
        par_acc <= par_acc ^ ser_in;
      end
      perr_q <= (state == PAR) ? (ser_in ^ par_acc) : 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl with an attached down counter.
// Each driven cycle pushes the expected outputs for that cycle, derived from
// the bit's position within the frame; a negedge monitor pops and compares.
module tb_serial_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_in = 1'b1;
  logic       cnt_co;
  logic       cnt_ld;
  logic       cnt_cen;
  logic [7:0] cnt_par_ld;
  logic [3:0] port_en;
  logic       ser_out;
  logic       busy;
  logic       done;
  logic       parity_err;
  logic [7:0] cnt_val;

  // Output vector layout: {ld, cen, port_en[3:0], ser_out, busy, done, perr}
  localparam logic [9:0] IDLE_O = 10'b00_0000_0000;
  localparam logic [9:0] BUSY_O = 10'b00_0000_0100;

  typedef struct {
    int         id;
    logic       chk_len;
    logic [7:0] len;
    logic [9:0] outs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  serial_frame_ctrl #(.PORT_W(2), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .cnt_co     (cnt_co),
    .cnt_ld     (cnt_ld),
    .cnt_cen    (cnt_cen),
    .cnt_par_ld (cnt_par_ld),
    .port_en    (port_en),
    .ser_out    (ser_out),
    .busy       (busy),
    .done       (done),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Loadable down counter driven by the controller.
  always @(posedge clk) begin
    if (rst)          cnt_val <= 8'd0;
    else if (cnt_ld)  cnt_val <= cnt_par_ld;
    else if (cnt_cen) cnt_val <= cnt_val - 8'd1;
  end
  assign cnt_co = (cnt_val == 8'd1);

  // Scoreboard monitor: compare each cycle's outputs at the falling edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [9:0] obs;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {cnt_ld, cnt_cen, port_en, ser_out, busy, done, parity_err};
      checks++;
      assert (obs === e.outs) else begin
        errors++;
        $error("FAIL outs step %0d: got %b expected %b", e.id, obs, e.outs);
      end
      if (e.chk_len) begin
        checks++;
        assert (cnt_par_ld === e.len) else begin
          errors++;
          $error("FAIL cnt_par_ld step %0d: got %0d expected %0d", e.id, cnt_par_ld, e.len);
        end
      end
    end
  end

  task automatic step(input logic r, input logic b, input logic [9:0] outs,
                      input logic chk, input logic [7:0] len);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    ser_in = b;
    e.id      = step_no;
    e.chk_len = chk;
    e.len     = len;
    e.outs    = outs;
    step_no++;
    sb.push_back(e);
  endtask

  // Drive one frame; data[i] is the i-th payload bit on the wire.
  // abort_at >= 0 asserts rst during that payload bit and ends the frame.
  task automatic frame(input logic [1:0] port, input int len, input logic [255:0] data,
                       input logic pbit, input logic done_in, input int abort_at);
    logic [7:0] lenv;
    logic [3:0] pe;
    logic       acc;
    logic       perr;
    lenv = 8'(len);
    pe   = 4'b0001 << port;
    acc  = 1'b0;
    step(1'b0, 1'b0, IDLE_O, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) step(1'b0, port[1-i], BUSY_O, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) step(1'b0, lenv[7-i], BUSY_O, 1'b0, 8'd0);
    step(1'b0, 1'($urandom_range(0, 1)), 10'b10_0000_0100, 1'b1, lenv);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        step(1'b1, data[i], {2'b01, pe, data[i], 3'b100}, 1'b0, 8'd0);
        step(1'b0, 1'b1, IDLE_O, 1'b1, 8'd0);
        return;
      end
      step(1'b0, data[i], {2'b01, pe, data[i], 3'b100}, 1'b0, 8'd0);
      acc = acc ^ data[i];
    end
`ifdef PARITY_EN
    step(1'b0, pbit, BUSY_O, 1'b0, 8'd0);
    perr = pbit ^ acc;
`else
    perr = 1'b0;
`endif
    step(1'b0, done_in, {7'b0, 2'b11, perr}, 1'b0, 8'd0);
  endtask

  initial begin
    logic [255:0] d;
    logic         p;

    // Reset held three cycles with ser_in toggling, then released idle.
    step(1'b1, 1'b0, IDLE_O, 1'b1, 8'd0);
    step(1'b1, 1'b1, IDLE_O, 1'b1, 8'd0);
    step(1'b1, 1'b0, IDLE_O, 1'b1, 8'd0);
    step(1'b0, 1'b1, IDLE_O, 1'b1, 8'd0);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);

    // Port 2, len 3, payload 1,0,1.
    frame(2'd2, 3, 256'b101, 1'b0, 1'b1, -1);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);

    // Port 1, len 0: load pulse only.
    frame(2'd1, 0, '0, 1'b0, 1'b1, -1);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);

    // Back-to-back frames, ser_in low during DONE must be ignored.
    frame(2'd3, 1, 256'b1, 1'b1, 1'b0, -1);
    frame(2'd0, 2, 256'b10, 1'b1, 1'b1, -1);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);

    // Reset during the third of five payload bits, then a clean frame.
    frame(2'd2, 5, 256'b01011, 1'b1, 1'b1, 2);
    frame(2'd1, 2, 256'b11, 1'b0, 1'b1, -1);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);

    // Maximum length payload with random data.
    d = '0;
    p = 1'b0;
    for (int i = 0; i < 255; i++) begin
      d[i] = 1'($urandom_range(0, 1));
      p    = p ^ d[i];
    end
    frame(2'd3, 255, d, p, 1'b1, -1);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);

`ifdef PARITY_EN
    // Payload 1101: correct parity 1, then wrong parity 0.
    frame(2'd1, 4, 256'b1011, 1'b1, 1'b1, -1);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);
    frame(2'd1, 4, 256'b1011, 1'b0, 1'b1, -1);
    step(1'b0, 1'b1, IDLE_O, 1'b0, 8'd0);
`endif

    // Let the monitor drain the scoreboard, bounded.
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
